// File: rtl/axil_csr_bridge.sv
// -----------------------------------------------------------------------------
// axil_csr_bridge
//
// AXI4-Lite slave front end for the accelerator CSR block. Each of the AW, W
// and AR channels has a one-beat holding register so the host can queue the
// next address/data while a response is still outstanding. A small FSM picks
// either a complete write (AW+W) or a read, issues a single-cycle CSR strobe,
// and then holds the AXI response until the host accepts it. Reads and writes
// that tie in IDLE are granted round-robin.
//
// Illegal accesses (misaligned address, or a write with partial byte strobes)
// are answered with SLVERR and never reach the CSR file. Every SLVERR response
// bumps a saturating counter.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   s_axi_aw*           write address channel
//   s_axi_w*            write data channel
//   s_axi_b*            write response channel (00 OKAY, 10 SLVERR)
//   s_axi_ar*           read address channel
//   s_axi_r*            read data / response channel
//   csr_wen, csr_ren    one-cycle CSR write / read strobes
//   csr_addr, csr_wdata CSR byte address and write data (0 when idle)
//   csr_rdata           CSR read data, combinational from csr_addr
//   slverr_count        saturating count of SLVERR responses
// -----------------------------------------------------------------------------
module axil_csr_bridge #(
  parameter int ADDR_W   = 8,
  parameter int ERRCNT_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [31:0]         s_axi_wdata,
  input  logic [3:0]          s_axi_wstrb,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [31:0]         s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic                csr_wen,
  output logic                csr_ren,
  output logic [ADDR_W-1:0]   csr_addr,
  output logic [31:0]         csr_wdata,
  input  logic [31:0]         csr_rdata,
  output logic [ERRCNT_W-1:0] slverr_count
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_ACC,
    WR_RESP,
    RD_ACC,
    RD_RESP
  } state_t;

  state_t              state;
  state_t              state_nxt;

  logic                aw_full;
  logic                w_full;
  logic                ar_full;
  logic [ADDR_W-1:0]   awaddr_q;
  logic [ADDR_W-1:0]   araddr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          wstrb_q;

  // 1 = the most recent grant went to the read side
  logic                last_grant_rd;

  logic                aw_hs;
  logic                w_hs;
  logic                ar_hs;
  logic                wr_rdy;
  logic                rd_rdy;
  logic                grant_wr;
  logic                grant_rd;
  logic                wr_legal;
  logic                rd_legal;

  function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
    if (&v) begin
      return v;
    end
    return v + ERRCNT_W'(1);
  endfunction

  // Ready is also held low while rst is asserted so no beat can slip in
  // during the reset cycle itself.
  assign s_axi_awready = !aw_full && !rst;
  assign s_axi_wready  = !w_full  && !rst;
  assign s_axi_arready = !ar_full && !rst;

  assign aw_hs = s_axi_awvalid && s_axi_awready;
  assign w_hs  = s_axi_wvalid  && s_axi_wready;
  assign ar_hs = s_axi_arvalid && s_axi_arready;

  assign wr_rdy = aw_full && w_full;
  assign rd_rdy = ar_full;

  assign wr_legal = (awaddr_q[1:0] == 2'b00) && (wstrb_q == 4'hF);
  assign rd_legal = (araddr_q[1:0] == 2'b00);

  assign s_axi_bvalid = (state == WR_RESP) && !rst;
  assign s_axi_rvalid = (state == RD_RESP) && !rst;

  always_comb begin
    state_nxt = state;
    grant_wr  = 1'b0;
    grant_rd  = 1'b0;
    case (state)
      IDLE: begin
        if (wr_rdy && rd_rdy) begin
          grant_wr = last_grant_rd;
          grant_rd = !last_grant_rd;
        end else begin
          grant_wr = wr_rdy;
          grant_rd = rd_rdy;
        end
        if (grant_wr) begin
          state_nxt = WR_ACC;
        end else if (grant_rd) begin
          state_nxt = RD_ACC;
        end
      end
      WR_ACC:  state_nxt = WR_RESP;
      WR_RESP: if (s_axi_bready) state_nxt = IDLE;
      RD_ACC:  state_nxt = RD_RESP;
      RD_RESP: if (s_axi_rready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // CSR side is driven only during the access cycle; illegal accesses still
  // present the address but never raise a strobe.
  always_comb begin
    csr_wen   = 1'b0;
    csr_ren   = 1'b0;
    csr_addr  = '0;
    csr_wdata = '0;
    if (!rst) begin
      case (state)
        WR_ACC: begin
          csr_addr  = awaddr_q;
          csr_wdata = wdata_q;
          csr_wen   = wr_legal;
        end
        RD_ACC: begin
          csr_addr = araddr_q;
          csr_ren  = rd_legal;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      aw_full       <= 1'b0;
      w_full        <= 1'b0;
      ar_full       <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      last_grant_rd <= 1'b1;
      s_axi_bresp   <= RESP_OKAY;
      s_axi_rresp   <= RESP_OKAY;
      s_axi_rdata   <= '0;
      slverr_count  <= '0;
    end else begin
      state <= state_nxt;

      // A holding register can only be refilled while empty, so capture and
      // the release in the access cycle never collide.
      if (aw_hs) begin
        aw_full  <= 1'b1;
        awaddr_q <= s_axi_awaddr;
      end else if (state == WR_ACC) begin
        aw_full <= 1'b0;
      end

      if (w_hs) begin
        w_full  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end else if (state == WR_ACC) begin
        w_full <= 1'b0;
      end

      if (ar_hs) begin
        ar_full  <= 1'b1;
        araddr_q <= s_axi_araddr;
      end else if (state == RD_ACC) begin
        ar_full <= 1'b0;
      end

      if (grant_wr) begin
        last_grant_rd <= 1'b0;
      end else if (grant_rd) begin
        last_grant_rd <= 1'b1;
      end

      if (state == WR_ACC) begin
        s_axi_bresp <= wr_legal ? RESP_OKAY : RESP_SLVERR;
        if (!wr_legal) begin
          slverr_count <= sat_inc(slverr_count);
        end
      end

      if (state == RD_ACC) begin
        s_axi_rdata <= rd_legal ? csr_rdata : 32'h0;
        s_axi_rresp <= rd_legal ? RESP_OKAY : RESP_SLVERR;
        if (!rd_legal) begin
          slverr_count <= sat_inc(slverr_count);
        end
      end
    end
  end

endmodule

// File: doc/axil_csr_bridge.md
Name: axil_csr_bridge

Overview:
AXI4-Lite slave shim that sits directly upstream of the accelerator CSR block. It converts host AXI-Lite write/read transactions into the single-cycle csr_wen/csr_ren/csr_addr/csr_wdata strobes and samples csr_rdata. It buffers the AW, W and AR channels independently, arbitrates reads against writes round-robin, and flags illegal accesses with SLVERR without touching the CSR file.

Parameters:
ADDR_W, 8, byte-address width of the CSR map (256B).
ERRCNT_W, 16, width of the saturating SLVERR counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bresp  out  2  write response (00 OKAY, 10 SLVERR)
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
csr_wen  out  1  one-cycle CSR write strobe
csr_ren  out  1  one-cycle CSR read strobe
csr_addr  out  ADDR_W  CSR byte address
csr_wdata  out  32  CSR write data
csr_rdata  in  32  CSR read data, combinational from csr_addr
slverr_count  out  ERRCNT_W  saturating count of SLVERR responses

Behaviour:
- Single clock clk. Reset is synchronous and active-high (rst); all state is cleared on the rst edge.
- Reset values: all *ready, bvalid, rvalid, csr_wen and csr_ren are 0; bresp, rresp, rdata, csr_addr, csr_wdata and slverr_count are 0. The FSM is in IDLE and all holding registers are empty.
- Holding registers: aw_full, w_full and ar_full each hold one beat.
  - awready = !aw_full; wready = !w_full; arready = !ar_full.
  - A handshake (valid && ready) sets the flag and captures the payload.
  - AW and W may arrive in either order or in the same cycle.
- FSM states: IDLE, WR_ACC, WR_RESP, RD_ACC, RD_RESP.
- IDLE arbitration:
  - wr_rdy = aw_full && w_full; rd_rdy = ar_full.
  - If only one is ready, grant it.
  - If both are ready, grant the opposite of last_grant (reset value = read, so the first tie goes to write).
  - last_grant updates on every grant. If neither is ready, stay in IDLE.
- WR_ACC (1 cycle):
  - csr_addr = captured awaddr; csr_wdata = captured wdata.
  - legal = (awaddr[1:0]==0) && (wstrb==4'hF).
  - csr_wen = legal.
  - bresp = legal ? OKAY : SLVERR.
  - Clear aw_full and w_full. Go to WR_RESP.
- WR_RESP: bvalid = 1 and is held with bresp stable until bready; then go to IDLE. Latency is 2 cycles from IDLE grant to bvalid.
- RD_ACC (1 cycle):
  - csr_addr = captured araddr; legal = (araddr[1:0]==0); csr_ren = legal.
  - Register rdata = legal ? csr_rdata : 32'h0; rresp = legal ? OKAY : SLVERR.
  - Clear ar_full. Go to RD_RESP.
- RD_RESP: rvalid = 1 and is held with rdata/rresp stable until rready; then go to IDLE.
- Unmapped but aligned addresses are forwarded as-is. The CSR returns 32'hDEAD_BEEF with OKAY; the bridge does no address decode.
- csr_addr and csr_wdata read 0 outside the ACC states. csr_wen and csr_ren are never high together and never high for more than 1 cycle per transaction.
- New beats may be accepted into empty holding registers during any state. This allows the next AW/W/AR to queue while a response is pending.
- slverr_count increments by 1 on each transition into WR_RESP/RD_RESP with SLVERR and saturates at all-ones. A simultaneous write and read error is impossible (only one access per cycle).
- Reset mid-transaction: any pending response is dropped, queued beats are discarded, and no CSR strobe is issued on or after the rst cycle.

Test Plan:
1. AW 0x04 and W 0x0000_0010 (strb F) in the same cycle -> csr_wen=1 for exactly 1 cycle with addr 0x04 / data 0x10; bvalid 2 cycles after grant with bresp=00.
2. W arrives 3 cycles before AW 0x10, data 0x2 -> wready drops after W captured; write issues only after AW; single csr_wen; bresp=00.
3. AR 0x3C with csr_rdata=0x0000_0003 -> csr_ren 1 cycle; rdata=0x3, rresp=00. Hold rready=0 for 5 cycles -> rvalid/rdata stable; arready=1 allows a second AR to queue.
4. Write to 0x06 and write to 0x08 with wstrb=4'h3 -> no csr_wen; bresp=10 both; slverr_count=2. Read 0x41 -> rresp=10, rdata=0, csr_ren=0, slverr_count=3.
5. Write and read both pending in IDLE, repeated for 4 pairs -> grants alternate W,R,W,R; no starvation.
6. Assert rst while in WR_RESP with AR queued -> next cycle bvalid=0, arready=1, slverr_count=0, and no csr_ren is issued for the dropped AR.
